// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    localparam logic [31:0] DEFAULT_ROM_LIMIT = 32'h1000_0000;
    localparam int          WAIT_CNT_W        = 4;

endpackage

// File: rtl/memory_arbiter_if.sv
// Fetch port, data port and memory-side bus of the arbiter.
interface memory_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_i;
    logic [DATA_WIDTH-1:0] if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [DATA_WIDTH-1:0] if_rdata_o;

    logic                  dm_req_i;
    logic                  dm_we_i;
    logic [DATA_WIDTH-1:0] dm_addr_i;
    logic [DATA_WIDTH-1:0] dm_wdata_i;
    logic                  dm_gnt_o;
    logic                  dm_rvalid_o;
    logic [DATA_WIDTH-1:0] dm_rdata_o;
    logic                  dm_err_o;

    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
        output mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o, dm_err_o,
        input  mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_arb_picker.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise data has fixed priority.
module mem_arb_picker
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  owner_t last_owner,
`endif
    input  logic   if_req,
    input  logic   dm_req,
    output logic   any_req,
    output owner_t winner
);

    assign any_req = if_req | dm_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the port that was not granted last time wins.
    always_comb begin
        winner = OWN_DM;
        if (if_req && dm_req) begin
            winner = (last_owner == OWN_DM) ? OWN_IF : OWN_DM;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end
`else
    assign winner = dm_req ? OWN_DM : OWN_IF;
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares one combinational-read memory between a fetch port and a data port,
// one registered access at a time; stores below ROM_LIMIT are refused and flagged.
// Optional macro MEM_ARB_ROUND_ROBIN_EN switches to round-robin arbitration.
module memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] ROM_LIMIT   = DATA_WIDTH'(DEFAULT_ROM_LIMIT),
    parameter int                    WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            reset,
    memory_arbiter_if.slave bus,
    output logic            busy_o
);

    state_t                  state_reg, state_next;
    owner_t                  owner_reg;
    logic [DATA_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic                    we_reg;
    logic [WAIT_CNT_W-1:0]   cnt_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;

    logic   any_req;
    owner_t winner;
    logic   grant;
    logic   last_access;
    logic   resp;
    logic   rom_hit;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t last_owner_reg;

    // Reset value OWN_IF makes the first tie after reset go to the data port.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_reg <= OWN_IF;
        end else if (grant) begin
            last_owner_reg <= winner;
        end
    end
`endif

    mem_arb_picker u_picker (
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner (last_owner_reg),
`endif
        .if_req     (bus.if_req_i),
        .dm_req     (bus.dm_req_i),
        .any_req    (any_req),
        .winner     (winner)
    );

    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        case (state_reg)
            IDLE, RESP: begin
                if (any_req) begin
                    grant      = 1'b1;
                    state_next = ACCESS;
                end else begin
                    state_next = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            grant      = 1'b0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= OWN_DM;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                owner_reg <= winner;
                addr_reg  <= (winner == OWN_DM) ? bus.dm_addr_i : bus.if_addr_i;
                we_reg    <= (winner == OWN_DM) && bus.dm_we_i;
                cnt_reg   <= WAIT_CNT_W'(WAIT_STATES);
                if (winner == OWN_DM) begin
                    wdata_reg <= bus.dm_wdata_i;
                end
            end else if (state_reg == ACCESS && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - WAIT_CNT_W'(1);
            end
            if (last_access) begin
                rdata_reg <= bus.mem_rdata_i;
            end
        end
    end

    // Outputs are gated by reset so an interrupted access never writes or responds.
    assign last_access = (state_reg == ACCESS) && (cnt_reg == '0);
    assign resp        = (state_reg == RESP) && !reset;
    assign rom_hit     = addr_reg < ROM_LIMIT;

    assign bus.if_gnt_o    = grant && (winner == OWN_IF);
    assign bus.dm_gnt_o    = grant && (winner == OWN_DM);
    assign bus.if_rvalid_o = resp && (owner_reg == OWN_IF);
    assign bus.dm_rvalid_o = resp && (owner_reg == OWN_DM);
    assign bus.dm_err_o    = bus.dm_rvalid_o && we_reg && rom_hit;
    assign bus.if_rdata_o  = rdata_reg;
    assign bus.dm_rdata_o  = rdata_reg;

    assign bus.mem_we_o    = last_access && we_reg && !rom_hit && !reset;
    assign bus.mem_addr_o  = addr_reg;
    assign bus.mem_wdata_o = wdata_reg;

    assign busy_o = (state_reg == ACCESS) && !reset;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench: table-driven single accesses, hand-written timing/reset
// sequences, and a randomized run against a schedule-based reference model.
module tb_memory_arbiter;
    import mem_arb_pkg::*;

    localparam logic [31:0] ROM_LIM = 32'h1000_0000;
    localparam int          WS3     = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst3, clr0, clr3;
    logic busy0, busy3;
    int   n_checks = 0;
    int   n_fails  = 0;

    memory_arbiter_if #(.DATA_WIDTH(32)) bus0();
    memory_arbiter_if #(.DATA_WIDTH(32)) bus3();

    memory_arbiter #(.DATA_WIDTH(32), .ROM_LIMIT(ROM_LIM), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst0), .bus(bus0), .busy_o(busy0));
    memory_arbiter #(.DATA_WIDTH(32), .ROM_LIMIT(ROM_LIM), .WAIT_STATES(WS3)) dut3 (
        .clk(clk), .reset(rst3), .bus(bus3), .busy_o(busy3));

    function automatic logic [9:0] midx(input logic [31:0] a);
        return {a[28], a[16], a[9:2]};
    endfunction

    function automatic logic [31:0] init_val(input logic [9:0] i);
        return (i == 10'h010) ? 32'h2010_0005 : (32'hC0DE_0000 | {22'd0, i});
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        base = ($urandom_range(0, 3) == 0) ? 32'h0FFF_FF00 : 32'h1000_0000;
        return base + ($urandom_range(0, 15) << 2);
    endfunction

    // Memory models: combinational read, write on clock edge.
    logic [31:0] ram0 [1024];
    logic        wr0  [1024];
    logic [31:0] ram3 [1024];
    logic        wr3  [1024];

    always @(posedge clk) begin
        if (clr0) begin
            for (int i = 0; i < 1024; i++) wr0[i] <= 1'b0;
        end else if (bus0.mem_we_o) begin
            ram0[midx(bus0.mem_addr_o)] <= bus0.mem_wdata_o;
            wr0[midx(bus0.mem_addr_o)]  <= 1'b1;
        end
    end
    always @(posedge clk) begin
        if (clr3) begin
            for (int i = 0; i < 1024; i++) wr3[i] <= 1'b0;
        end else if (bus3.mem_we_o) begin
            ram3[midx(bus3.mem_addr_o)] <= bus3.mem_wdata_o;
            wr3[midx(bus3.mem_addr_o)]  <= 1'b1;
        end
    end
    assign bus0.mem_rdata_i = wr0[midx(bus0.mem_addr_o)] ? ram0[midx(bus0.mem_addr_o)]
                                                         : init_val(midx(bus0.mem_addr_o));
    assign bus3.mem_rdata_i = wr3[midx(bus3.mem_addr_o)] ? ram3[midx(bus3.mem_addr_o)]
                                                         : init_val(midx(bus3.mem_addr_o));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn0(input bit is_dm, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int gnt_wait, output int rv_lat,
                        output int we_cnt, output int busy_cnt, output logic [31:0] rdata,
                        output logic err, output bit stray_rv, output bit bus_ok);
        step();
        if (is_dm) begin
            bus0.dm_req_i = 1'b1; bus0.dm_we_i = we; bus0.dm_addr_i = addr; bus0.dm_wdata_i = wdata;
        end else begin
            bus0.if_req_i = 1'b1; bus0.if_addr_i = addr;
        end
        gnt_wait = -1; rv_lat = -1; we_cnt = 0; busy_cnt = 0;
        rdata = '0; err = 1'b0; stray_rv = 1'b0; bus_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (is_dm ? bus0.dm_gnt_o : bus0.if_gnt_o) begin
                gnt_wait = k;
                break;
            end
            step();
        end
        step();
        bus0.dm_req_i = 1'b0;
        bus0.if_req_i = 1'b0;
        if (gnt_wait >= 0) begin
            for (int c = 1; c < 12; c++) begin
                #1;
                if (busy0) begin
                    busy_cnt++;
                    if (bus0.mem_addr_o !== addr) bus_ok = 1'b0;
                    if (is_dm && we && bus0.mem_wdata_o !== wdata) bus_ok = 1'b0;
                end
                if (bus0.mem_we_o) we_cnt++;
                if (is_dm ? bus0.if_rvalid_o : bus0.dm_rvalid_o) stray_rv = 1'b1;
                if (is_dm ? bus0.dm_rvalid_o : bus0.if_rvalid_o) begin
                    rv_lat = c;
                    rdata  = is_dm ? bus0.dm_rdata_o : bus0.if_rdata_o;
                    err    = bus0.dm_err_o;
                    break;
                end
                step();
            end
        end
    endtask

    task automatic load3(input logic [31:0] addr, output logic [31:0] data, output int lat);
        step();
        bus3.dm_req_i = 1'b1; bus3.dm_we_i = 1'b0; bus3.dm_addr_i = addr;
        lat = -1; data = '0;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (bus3.dm_rvalid_o) begin
                lat = c; data = bus3.dm_rdata_o;
                break;
            end
            step();
            if (c == 0) bus3.dm_req_i = 1'b0;
        end
        bus3.dm_req_i = 1'b0;
    endtask

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          chk_rdata;
        bit          exp_err;
        int          exp_we;
    } vec_t;

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [10];
        int          gw, rl, wc, bc, lat;
        logic [31:0] rd;
        logic        er;
        bit          srv, bok;
        logic [6:0]  gnt_v, busy_v, we_v, rv_v;
        logic [1:0]  pair, exp_pair;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          32'h2010_0005, 1'b1, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0, 1};
        vecs[2] = '{1'b1, 1'b0, 32'h1001_0000, 32'h0,          32'hDEAD_BEEF, 1'b1, 1'b0, 0};
        vecs[3] = '{1'b1, 1'b1, 32'h0FFF_FFFC, 32'h1111_2222, 32'h0,         1'b0, 1'b1, 0};
        vecs[4] = '{1'b1, 1'b0, 32'h0FFF_FFFC, 32'h0,          32'hC0DE_01FF, 1'b1, 1'b0, 0};
        vecs[5] = '{1'b1, 1'b1, 32'h1000_0000, 32'h3333_4444, 32'h0,         1'b0, 1'b0, 1};
        vecs[6] = '{1'b1, 1'b0, 32'h1000_0000, 32'h0,          32'h3333_4444, 1'b1, 1'b0, 0};
        vecs[7] = '{1'b1, 1'b1, 32'h0FFF_FFFF, 32'h5555_6666, 32'h0,         1'b0, 1'b1, 0};
        vecs[8] = '{1'b0, 1'b0, 32'h1001_0000, 32'h0,          32'hDEAD_BEEF, 1'b1, 1'b0, 0};
        vecs[9] = '{1'b1, 1'b0, 32'h0FFF_FFF8, 32'h0,          32'hC0DE_01FE, 1'b1, 1'b0, 0};

        rst0 = 1'b1; rst3 = 1'b1; clr0 = 1'b1; clr3 = 1'b1;
        bus0.if_req_i = 1'b0; bus0.if_addr_i = '0; bus0.dm_req_i = 1'b1; bus0.dm_we_i = 1'b0;
        bus0.dm_addr_i = '0; bus0.dm_wdata_i = '0;
        bus3.if_req_i = 1'b0; bus3.if_addr_i = '0; bus3.dm_req_i = 1'b0; bus3.dm_we_i = 1'b0;
        bus3.dm_addr_i = '0; bus3.dm_wdata_i = '0;

        // Reset state, with a data request present that must not be granted.
        step(); step();
        #1;
        check("reset_ctl0", {25'd0, bus0.if_gnt_o, bus0.dm_gnt_o, bus0.if_rvalid_o, bus0.dm_rvalid_o,
                             bus0.dm_err_o, bus0.mem_we_o, busy0}, 32'h0);
        check("reset_addr0", bus0.mem_addr_o, 32'h0);
        check("reset_rdata0", bus0.dm_rdata_o, 32'h0);
        check("reset_ctl3", {25'd0, bus3.if_gnt_o, bus3.dm_gnt_o, bus3.if_rvalid_o, bus3.dm_rvalid_o,
                             bus3.dm_err_o, bus3.mem_we_o, busy3}, 32'h0);
        bus0.dm_req_i = 1'b0;
        rst0 = 1'b0; rst3 = 1'b0; clr0 = 1'b0; clr3 = 1'b0;

        // Table-driven single accesses, WAIT_STATES = 0.
        for (int v = 0; v < 10; v++) begin
            txn0(vecs[v].is_dm, vecs[v].we, vecs[v].addr, vecs[v].wdata, gw, rl, wc, bc, rd, er, srv, bok);
            check($sformatf("vec%0d_gnt_wait", v), gw, 0);
            check($sformatf("vec%0d_rvalid_lat", v), rl, 2);
            check($sformatf("vec%0d_busy_cycles", v), bc, 1);
            check($sformatf("vec%0d_we_pulses", v), wc, vecs[v].exp_we);
            check($sformatf("vec%0d_err", v), {31'd0, er}, {31'd0, vecs[v].exp_err});
            check($sformatf("vec%0d_other_rvalid", v), {31'd0, srv}, 32'd0);
            check($sformatf("vec%0d_mem_bus", v), {31'd0, bok}, 32'd1);
            if (vecs[v].chk_rdata) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            $display("vec %0d: dm=%0b we=%0b addr=%h rdata=%h err=%0b we_pulses=%0d",
                     v, vecs[v].is_dm, vecs[v].we, vecs[v].addr, rd, er, wc);
        end

        // Both ports held continuously after a fresh reset.
        step(); rst0 = 1'b1; step(); rst0 = 1'b0;
        bus0.dm_req_i = 1'b1; bus0.dm_we_i = 1'b0; bus0.dm_addr_i = 32'h1000_0000;
        bus0.if_req_i = 1'b1; bus0.if_addr_i = 32'h0000_0040;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            pair = {bus0.if_gnt_o, bus0.dm_gnt_o};
            if (cyc % 2 == 1) exp_pair = 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            else exp_pair = ((cyc / 2) % 2 == 0) ? 2'b01 : 2'b10;
`else
            else exp_pair = 2'b01;
`endif
            check($sformatf("tie_cycle%0d_gnt", cyc), {30'd0, pair}, {30'd0, exp_pair});
            $display("tie cycle %0d: if_gnt=%0b dm_gnt=%0b", cyc, pair[1], pair[0]);
            step();
        end
        bus0.dm_req_i = 1'b0; bus0.if_req_i = 1'b0;
        step(); step();

        // WAIT_STATES = 3 store: per-cycle timing profile.
        step();
        bus3.dm_req_i = 1'b1; bus3.dm_we_i = 1'b1; bus3.dm_addr_i = 32'h1000_0010;
        bus3.dm_wdata_i = 32'h5A5A_1234;
        for (int cyc = 0; cyc < 7; cyc++) begin
            #1;
            gnt_v[cyc] = bus3.dm_gnt_o; busy_v[cyc] = busy3;
            we_v[cyc] = bus3.mem_we_o; rv_v[cyc] = bus3.dm_rvalid_o;
            step();
            if (cyc == 0) bus3.dm_req_i = 1'b0;
        end
        check("ws3_gnt_profile", {25'd0, gnt_v}, 32'b0000001);
        check("ws3_busy_profile", {25'd0, busy_v}, 32'b0011110);
        check("ws3_we_profile", {25'd0, we_v}, 32'b0010000);
        check("ws3_rvalid_profile", {25'd0, rv_v}, 32'b0100000);
        load3(32'h1000_0010, rd, lat);
        check("ws3_load_lat", lat, 5);
        check("ws3_load_data", rd, 32'h5A5A_1234);
        $display("ws3 store/load: busy=%b we=%b rv=%b data=%h", busy_v, we_v, rv_v, rd);

        // Reset asserted in the last ACCESS cycle of a RAM store.
        step();
        bus3.dm_req_i = 1'b1; bus3.dm_we_i = 1'b1; bus3.dm_addr_i = 32'h1000_0020;
        bus3.dm_wdata_i = 32'h7777_8888;
        #1;
        check("rst_mid_gnt", {31'd0, bus3.dm_gnt_o}, 32'd1);
        step(); bus3.dm_req_i = 1'b0;
        step(); step(); step();
        rst3 = 1'b1;
        #1;
        check("rst_mid_we", {30'd0, bus3.mem_we_o, busy3}, 32'd0);
        step();
        rst3 = 1'b0;
        #1;
        check("rst_after_ctl", {25'd0, bus3.if_gnt_o, bus3.dm_gnt_o, bus3.if_rvalid_o, bus3.dm_rvalid_o,
                                bus3.dm_err_o, bus3.mem_we_o, busy3}, 32'h0);
        check("rst_after_addr", bus3.mem_addr_o, 32'h0);
        check("rst_after_wdata", bus3.mem_wdata_o, 32'h0);
        check("rst_after_rdata", bus3.dm_rdata_o | bus3.if_rdata_o, 32'h0);
        srv = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            step(); #1;
            if (bus3.dm_rvalid_o || bus3.if_rvalid_o || bus3.mem_we_o) srv = 1'b1;
        end
        check("rst_no_late_activity", {31'd0, srv}, 32'd0);
        load3(32'h1000_0020, rd, lat);
        check("rst_store_dropped", rd, 32'hC0DE_0208);
        check("rst_idle_lat", lat, 5);
        $display("reset mid-access: readback=%h lat=%0d", rd, lat);

        // Randomized traffic on the WAIT_STATES = 3 instance.
        begin
            logic [31:0] exp_mem [1024];
            bit          dm_pend, if_pend, dm_out, if_out, dm_drop, if_drop;
            bit          exp_ig, exp_dg, dm_chk, dm_exp_err;
            int          free_at, dm_rv_at, if_rv_at, we_at;
            owner_t      last, w;
            logic [31:0] dm_exp_data, if_exp_data, a;
            logic [5:0]  exp_v, act_v;

            step(); rst3 = 1'b1; clr3 = 1'b1; step(); rst3 = 1'b0; clr3 = 1'b0;
            for (int i = 0; i < 1024; i++) exp_mem[i] = init_val(10'(i));
            dm_pend = 0; if_pend = 0; dm_out = 0; if_out = 0; dm_drop = 0; if_drop = 0;
            dm_chk = 0; dm_exp_err = 0; free_at = 0; dm_rv_at = -1; if_rv_at = -1; we_at = -1;
            last = OWN_IF; dm_exp_data = '0; if_exp_data = '0;
            for (int c = 0; c < 600; c++) begin
                step();
                if (dm_drop) begin bus3.dm_req_i = 1'b0; dm_drop = 0; end
                if (if_drop) begin bus3.if_req_i = 1'b0; if_drop = 0; end
                if (!dm_pend && !dm_out && $urandom_range(0, 2) == 0) begin
                    dm_pend = 1; bus3.dm_req_i = 1'b1; bus3.dm_we_i = 1'($urandom_range(0, 1));
                    bus3.dm_addr_i = rand_addr(); bus3.dm_wdata_i = $urandom;
                end
                if (!if_pend && !if_out && $urandom_range(0, 2) == 0) begin
                    if_pend = 1; bus3.if_req_i = 1'b1; bus3.if_addr_i = rand_addr();
                end
                exp_ig = 0; exp_dg = 0;
                if (c >= free_at && (dm_pend || if_pend)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (dm_pend && if_pend) w = (last == OWN_DM) ? OWN_IF : OWN_DM;
                    else w = dm_pend ? OWN_DM : OWN_IF;
`else
                    w = dm_pend ? OWN_DM : OWN_IF;
`endif
                    last = w;
                    free_at = c + 2 + WS3;
                    if (w == OWN_DM) begin
                        exp_dg = 1; dm_pend = 0; dm_out = 1; dm_drop = 1; dm_rv_at = c + 2 + WS3;
                        a = bus3.dm_addr_i;
                        dm_exp_data = exp_mem[midx(a)];
                        dm_chk = !bus3.dm_we_i;
                        dm_exp_err = bus3.dm_we_i && (a < ROM_LIM);
                        if (bus3.dm_we_i && a >= ROM_LIM) begin
                            exp_mem[midx(a)] = bus3.dm_wdata_i;
                            we_at = c + 1 + WS3;
                        end
                    end else begin
                        exp_ig = 1; if_pend = 0; if_out = 1; if_drop = 1; if_rv_at = c + 2 + WS3;
                        if_exp_data = exp_mem[midx(bus3.if_addr_i)];
                    end
                end
                exp_v = {exp_ig, exp_dg, c == if_rv_at, c == dm_rv_at,
                         (c == dm_rv_at) && dm_exp_err, c == we_at};
                #1;
                act_v = {bus3.if_gnt_o, bus3.dm_gnt_o, bus3.if_rvalid_o, bus3.dm_rvalid_o,
                         bus3.dm_err_o, bus3.mem_we_o};
                check($sformatf("rand_c%0d_ctl", c), {26'd0, act_v}, {26'd0, exp_v});
                if (c == dm_rv_at && dm_chk) check($sformatf("rand_c%0d_dm_rdata", c), bus3.dm_rdata_o, dm_exp_data);
                if (c == if_rv_at) check($sformatf("rand_c%0d_if_rdata", c), bus3.if_rdata_o, if_exp_data);
                if (act_v != 6'd0 || exp_v != 6'd0)
                    $display("rand cycle %0d: gnt if/dm=%0b%0b rv if/dm=%0b%0b err=%0b we=%0b",
                             c, act_v[5], act_v[4], act_v[3], act_v[2], act_v[1], act_v[0]);
                if (c == dm_rv_at) dm_out = 0;
                if (c == if_rv_at) if_out = 0;
            end
            bus3.dm_req_i = 1'b0; bus3.if_req_i = 1'b0;
            for (int i = 0; i < 8; i++) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter and access sequencer in front of `Memory_System`, the unified memory where ROM sits below `ROM_LIMIT` and RAM sits at or above it. The arbiter shares that single memory between the instruction-fetch port (read-only) and the data port (load/store). It does this by registering one request at a time, driving the memory for a programmable number of cycles and returning a registered response to the owner. It also blocks stores into the ROM region and flags them.

## Interface
- `DATA_WIDTH`, 32: width of addresses and data.
- `ROM_LIMIT`, 32'h1000_0000: addresses below this are ROM; stores to them are refused.
- `WAIT_STATES`, 0: extra memory cycles per access (0–15).
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req_i`  in  1  fetch request; held with `if_addr_i` until granted.
- `if_addr_i`  in  DATA_WIDTH  fetch address.
- `if_gnt_o`  out  1  one-cycle pulse: fetch request accepted this cycle.
- `if_rvalid_o`  out  1  one-cycle pulse: `if_rdata_o` valid.
- `if_rdata_o`  out  DATA_WIDTH  fetch read data.
- `dm_req_i`  in  1  data request; held with its fields until granted.
- `dm_we_i`  in  1  1 = store, 0 = load.
- `dm_addr_i`  in  DATA_WIDTH  data address.
- `dm_wdata_i`  in  DATA_WIDTH  store data.
- `dm_gnt_o`  out  1  one-cycle pulse: data request accepted.
- `dm_rvalid_o`  out  1  one-cycle pulse: data access complete; `dm_rdata_o` valid for loads.
- `dm_rdata_o`  out  DATA_WIDTH  load data.
- `dm_err_o`  out  1  pulses with `dm_rvalid_o` when a store targeted ROM.
- `mem_we_o`  out  1  write enable to the memory.
- `mem_addr_o`  out  DATA_WIDTH  memory address.
- `mem_wdata_o`  out  DATA_WIDTH  memory write data.
- `mem_rdata_i`  in  DATA_WIDTH  memory read data, combinational from `mem_addr_o`.
- `busy_o`  out  1  high in ACCESS.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE / RESP arbitration:** if any request is present, pick a winner and pulse its `gnt`. Latch owner, address, write data, and `we` (fetch owner forces we=0). Load the wait counter with `WAIT_STATES`, then go to ACCESS. With no request: RESP goes to IDLE, and IDLE stays in IDLE.
- **ACCESS:** `mem_addr_o` and `mem_wdata_o` are driven from the latched registers.
  - Counter > 0: decrement and stay in ACCESS.
  - Counter = 0 (last ACCESS cycle): capture `mem_rdata_i` into the shared rdata register. Assert `mem_we_o` only in this cycle, and only if latched we=1 and address ≥ `ROM_LIMIT`. Then go to RESP.
- **RESP:** pulse `rvalid` of the owner. `dm_err_o` = latched we and address < `ROM_LIMIT`. A store refused this way never writes.
- **Read data:** `if_rdata_o` and `dm_rdata_o` both carry the shared rdata register. Each is meaningful only with its own `rvalid`. The value is held until the next capture.
- **Priority:** the data port wins when both ports request (fixed priority).
- **Outputs with no access:** `mem_we_o` = 0. Address and write-data outputs hold their last values.

## Timing
- **Request sampled in cycle N:**
  - `gnt` is high in cycle N.
  - ACCESS spans cycles N+1 through N+1+`WAIT_STATES`.
  - `rvalid` is high in cycle N+2+`WAIT_STATES`.
- **Back-to-back:** a new grant may occur in the RESP cycle. The peak rate is one access every `WAIT_STATES`+2 cycles.
- **Requests arriving outside IDLE/RESP:** requests raised during ACCESS wait; the arbiter never drops a held request.
- **Reset values:** on any cycle with `reset` = 1, the next state is IDLE.
  - All `gnt`, `rvalid`, `err`, `mem_we_o` and `busy_o` outputs are 0.
  - `mem_addr_o`, `mem_wdata_o` and the rdata register are 0.
  - The round-robin pointer selects data next.
- **Reset mid-access:** the access is discarded with no `rvalid`. A pending write is not performed.
- **Store to address exactly `ROM_LIMIT`:** this is RAM, so it is written and `dm_err_o` = 0. Address `ROM_LIMIT`-1 is ROM and is refused.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - **Defined:** round-robin arbitration. On a tie, the port not granted most recently wins, and the pointer updates on every grant. After reset, the first tie goes to the data port.
  - **Undefined:** fixed priority, data over fetch, with no pointer register.

## Structure
- **Package `mem_arb_pkg`:**
  - state enum {IDLE, ACCESS, RESP};
  - owner enum {OWN_IF, OWN_DM};
  - default `ROM_LIMIT` constant;
  - wait-counter width constant (4).
- **Sub-module `mem_arb_picker`:** combinational. Takes both request lines and the last owner, and returns the winner. It contains the `MEM_ARB_ROUND_ROBIN_EN` selection.

## Test plan
- **Fetch read, `WAIT_STATES`=0:** fetch at 0x0000_0040 alone with `mem_rdata_i`=0x2010_0005 → `if_gnt_o` in cycle 0, `if_rvalid_o` in cycle 2 with `if_rdata_o`=0x2010_0005, `dm_rvalid_o` stays 0.
- **Data store then load:** store 0xDEAD_BEEF to 0x1001_0000, then load from the same address → exactly one `mem_we_o` pulse, then `dm_rdata_o`=0xDEAD_BEEF and `dm_err_o`=0.
- **Store to ROM region:** store to 0x0FFF_FFFC → `mem_we_o` never rises, and `dm_rvalid_o` and `dm_err_o` pulse together. A store to 0x1000_0000 writes with no error.
- **Simultaneous requests, held continuously:**
  - Round-robin defined: grants alternate DM, IF, DM, IF.
  - Round-robin undefined: only DM is granted while `dm_req_i` is held.
- **`WAIT_STATES`=3:** `busy_o` is high 4 cycles, `rvalid` arrives at cycle 5, and `mem_we_o` is high only in the 4th ACCESS cycle.
- **Reset during ACCESS of a RAM store:** no `mem_we_o`, no `rvalid`, all outputs 0 the next cycle, and the arbiter returns to IDLE.
